// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - vending transaction sequencer: coin edge detect, credit, vend, change
// Credit is counted in nickels; change and refunds leave as serial nickel_out pulses.
module vend_txn_controller #(
  parameter int CW             = 4,
  parameter int PRICE_A        = 3,
  parameter int PRICE_B        = 4,
  parameter int PRICE_C        = 5,
  parameter int PRICE_D        = 6,
  parameter int MAX_CREDIT     = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    item_number,
  input  logic          nickel_in,
  input  logic          dime_in,
  input  logic          cancel,
  output logic          dispense,
  output logic [3:0]    vend_item,
  output logic          nickel_out,
  output logic          coin_reject,
  output logic          item_err,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          nickel_sync_q, nickel_prev_q;
  logic          dime_sync_q, dime_prev_q;
  logic [CW-1:0] credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    vend_item_q, vend_item_d;
  logic          coin_reject_q, coin_reject_d;
  logic          change_hi_q, change_hi_d;

  logic          nickel_edge, dime_edge, coin_any, coin_open, coin_fits, coin_accept;
  logic [1:0]    coin_val;
  logic [CW+1:0] credit_sum;
  logic          item_onehot, timed_out;
  logic [CW-1:0] item_price, vend_price, credit_left;

  function automatic logic [CW-1:0] price_of(input logic [3:0] item);
    case (item)
      4'b0001: price_of = CW'(PRICE_A);
      4'b0010: price_of = CW'(PRICE_B);
      4'b0100: price_of = CW'(PRICE_C);
      4'b1000: price_of = CW'(PRICE_D);
      default: price_of = '0;
    endcase
  endfunction

  // Nickel and dime edges together encode the coin value directly: {dime, nickel}.
  assign nickel_edge = nickel_sync_q & ~nickel_prev_q;
  assign dime_edge   = dime_sync_q & ~dime_prev_q;
  assign coin_val    = {dime_edge, nickel_edge};
  assign coin_any    = nickel_edge | dime_edge;
  assign credit_sum  = {2'b00, credit_q} + (CW+2)'(coin_val);
  assign coin_fits   = credit_sum <= (CW+2)'(MAX_CREDIT);
  assign coin_open   = (state_q == S_IDLE) || (state_q == S_CREDIT);
  assign coin_accept = coin_any & coin_open & coin_fits;

  assign item_onehot = (item_number != 4'd0) && ((item_number & (item_number - 4'd1)) == 4'd0);
  assign item_price  = price_of(item_number);
  assign vend_price  = price_of(vend_item_q);
  assign credit_left = credit_q - vend_price;
  assign timed_out   = timer_q == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (coin_accept) state_d = S_CREDIT;
      end
      S_CREDIT: begin
        if (cancel || timed_out) begin
          state_d = S_CHANGE;
        end else if (item_onehot && (credit_q >= item_price)) begin
          state_d = S_VEND;
        end
      end
      S_VEND: begin
        state_d = (credit_left != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if ((credit_q == '0) || (change_hi_q && (credit_q == CW'(1)))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dispense    = (state_q == S_VEND);
    nickel_out  = (state_q == S_CHANGE) && change_hi_q;
    busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
    vend_item   = vend_item_q;
    coin_reject = coin_reject_q;
    credit      = credit_q;
    item_err    = (item_number != 4'd0) && !item_onehot;
  end

  always_comb begin
    credit_d      = credit_q;
    timer_d       = '0;
    vend_item_d   = vend_item_q;
    coin_reject_d = coin_any & ~coin_accept;
    // Every entry into CHANGE starts on a high (paying) cycle.
    change_hi_d   = (state_q == S_CHANGE) ? ~change_hi_q : 1'b1;
    case (state_q)
      S_IDLE: begin
        if (coin_accept) credit_d = credit_sum[CW-1:0];
      end
      S_CREDIT: begin
        if (coin_accept) begin
          credit_d = credit_sum[CW-1:0];
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (state_d == S_VEND) vend_item_d = item_number;
      end
      S_VEND: begin
        credit_d = credit_left;
      end
      S_CHANGE: begin
        if (change_hi_q && (credit_q != '0)) credit_d = credit_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nickel_sync_q <= 1'b1;
      nickel_prev_q <= 1'b1;
      dime_sync_q   <= 1'b1;
      dime_prev_q   <= 1'b1;
      credit_q      <= '0;
      timer_q       <= '0;
      vend_item_q   <= 4'd0;
      coin_reject_q <= 1'b0;
      change_hi_q   <= 1'b1;
    end else begin
      nickel_sync_q <= nickel_in;
      nickel_prev_q <= nickel_sync_q;
      dime_sync_q   <= dime_in;
      dime_prev_q   <= dime_sync_q;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      change_hi_q   <= change_hi_d;
    end
  end

endmodule
